cpu_pio_capture: RTL
====================

// Module: cpu_pio_capture
// PURPOSE
//  Parametrised Avalon-MM input PIO: successor to the fixed 10-bit read-only input port.
//  Adds an input synchroniser, per-bit rise/fall edge capture with W1C clear, an IRQ mask,
//  and a timestamp-free sample FIFO that logs the whole input word on every captured edge.
//  Sits between the FPGA fabric (DDS/ADC status lines) and the Nios II data master.
// PARAMETERS
//  WIDTH        10  input port width, 1..32
//  SYNC_STAGES   2  synchroniser flops on in_port, 2..4
//  FIFO_DEPTH    8  sample FIFO entries, power of 2, 2..256
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      synchronous active-low reset
//  address    in   3      Avalon word address
//  chipselect in   1      Avalon slave select
//  read       in   1      read strobe (pops FIFO at addr 4)
//  write_n    in   1      active-low write strobe
//  writedata  in   32     write data
//  in_port    in   WIDTH  asynchronous input lines
//  readdata   out  32     registered read data, unused bits 0
//  irq        out  1      level interrupt
// BEHAVIOUR
//  Reset: all registers 0 (sync chain, prev, mask, capture, ctrl, FIFO ptrs/level, overflow,
//   warm-up counter); readdata=0, irq=0.
//  Sync: s = last stage of SYNC_STAGES chain; p = s delayed 1 cycle.
//  Warm-up: counter runs 0..SYNC_STAGES+1 after reset release; edge events forced 0 until it
//   saturates (no false edges from reset-zeroed chain). Re-arms on every reset.
//  Event[i] = (ctrl[0] & s[i] & ~p[i]) | (ctrl[1] & ~s[i] & p[i]).
//  Register map (write = chipselect & ~write_n; rd = chipselect & read):
//   0 DATA   RO  s (synchronised in_port)
//   1 MASK   RW  [WIDTH-1:0]
//   2 EDGE   R/W1C  capture bits; capture <= (capture & ~wclr) | event; set wins over clear
//   3 CTRL   RW  b0 rise_en, b1 fall_en, b2 fifo_en; writing b2=0 flushes FIFO (level=0),
//                overflow kept
//   4 FIFO   RO-pop  oldest sample (WIDTH bits); 0 if empty; rd & !empty pops
//   5 STATUS [15:0] level, b16 empty, b17 full, b31 overflow (sticky, W1C via b31)
//   6,7      read 0, writes ignored
//  readdata: registered every cycle from mux of address; 1-cycle latency, no waitstates.
//   addr 4 returns head as of the request cycle.
//  irq = |(capture & mask), driven from registers, asserts the cycle after capture sets.
//  FIFO push: fifo_en & |event, data = s. Full & push & no pop -> sample dropped,
//   overflow<=1. Full & push & pop same cycle -> both occur, level unchanged, no overflow.
//   Empty & push & pop -> pop ignored (reads 0), push lands, level=1.
//  Pointers wrap modulo FIFO_DEPTH; level width clog2(FIFO_DEPTH)+1.
//  Reset mid-operation: FIFO contents lost, all state per reset list, warm-up restarts.
// TESTING
//  1 in_port=10'h3FF held through reset, ctrl=3 -> no EDGE bits, irq=0 after warm-up.
//  2 ctrl=1, mask=1, in_port bit0 0->1 -> EDGE=1 after SYNC_STAGES+1 clk, irq=1 next; write
//    EDGE=1 -> irq=0; clear coinciding with new edge -> bit stays 1.
//  3 ctrl=7, 3 rising edges with in_port=0x001,0x003,0x007 -> STATUS level=3; three addr-4
//    reads return 1,3,7; fourth returns 0, empty=1.
//  4 FIFO_DEPTH=8, 9 edges, no reads -> level=8, full=1, overflow=1, 9th sample absent;
//    STATUS write b31=1 -> overflow=0.
//  5 full FIFO, pop and edge same cycle -> level stays 8, overflow=0, new sample at tail.
//  6 ctrl 7->3 with level=5 -> level=0, empty=1; DATA read tracks in_port with 1+SYNC_STAGES lag.

Source files
------------

// File: rtl/cpu_pio_capture.sv
// cpu_pio_capture: parametrised Avalon-MM input PIO for the Nios II data master.
// Synchronises in_port, captures per-bit rising/falling edges (W1C), raises a
// masked level interrupt and logs the whole input word into a sample FIFO on
// every captured edge. Read data is registered with a fixed 1-cycle latency.
module cpu_pio_capture #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int WARM_MAX = SYNC_STAGES + 1;
    localparam int WARM_W   = $clog2(WARM_MAX + 1);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_EDGE   = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_FIFO   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    // Synchroniser chain: element 0 is nearest the pins, the top element is the safe sample.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [WARM_W-1:0]                 r_warm;

    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_capture;
    logic [2:0]       r_ctrl;
    logic             r_overflow;
    logic             r_irq;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic [WIDTH-1:0] w_s;
    logic             w_warm_done;
    logic [WIDTH-1:0] w_event;
    logic             w_wr;
    logic             w_rd;
    logic             w_empty;
    logic             w_full;
    logic             w_flush;
    logic             w_pop;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;
    logic [WIDTH-1:0] w_wclr;
    logic [WIDTH-1:0] w_head;
    logic [31:0]      w_rdata;
    logic             w_unused_wd;

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_warm_done = (r_warm == WARM_W'(WARM_MAX));
    // Edges are suppressed until the reset-zeroed chain has been refilled with real samples.
    assign w_event     = w_warm_done ? (({WIDTH{r_ctrl[0]}} &  w_s & ~r_prev) |
                                        ({WIDTH{r_ctrl[1]}} & ~w_s &  r_prev)) : '0;

    assign w_wr        = chipselect & ~write_n;
    assign w_rd        = chipselect & read;
    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_flush     = w_wr & (address == ADDR_CTRL) & ~writedata[2];
    assign w_pop       = w_rd & (address == ADDR_FIFO) & ~w_empty;
    // A flush takes priority: no sample is pushed or dropped in the flushing cycle.
    assign w_push_req  = r_ctrl[2] & (|w_event) & ~w_flush;
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & w_full & ~w_pop;
    assign w_wclr      = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign w_head      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign w_unused_wd = ^writedata;

    // Read-data multiplexer, sampled every cycle into r_readdata.
    always_comb begin
        // NOTE: defaulting every output of a combinational block first means no path leaves it unassigned, so no latch is inferred.
        w_rdata = '0;
        case (address)
            ADDR_DATA:   w_rdata[WIDTH-1:0] = w_s;
            ADDR_MASK:   w_rdata[WIDTH-1:0] = r_mask;
            ADDR_EDGE:   w_rdata[WIDTH-1:0] = r_capture;
            ADDR_CTRL:   w_rdata[2:0]       = r_ctrl;
            ADDR_FIFO:   w_rdata[WIDTH-1:0] = w_head;
            ADDR_STATUS: begin
                w_rdata[LVL_W-1:0] = r_level;
                w_rdata[16]        = w_empty;
                w_rdata[17]        = w_full;
                w_rdata[31]        = r_overflow;
            end
            default:     w_rdata = '0;
        endcase
    end

    // Input synchroniser, previous-sample register and post-reset warm-up counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= '0;
            r_warm <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain advances exactly one stage per clock.
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_prev <= w_s;
            if (!w_warm_done) begin
                r_warm <= r_warm + WARM_W'(1);
            end
        end
    end

    // Control/status registers, edge capture, interrupt and registered read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mask     <= '0;
            r_capture  <= '0;
            r_ctrl     <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (w_wr && address == ADDR_MASK) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            if (w_wr && address == ADDR_CTRL) begin
                r_ctrl <= writedata[2:0];
            end
            // A new edge in the same cycle as its clear keeps the bit set.
            r_capture <= (r_capture & ~w_wclr) | w_event;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_wr && address == ADDR_STATUS && writedata[31]) begin
                r_overflow <= 1'b0;
            end
            r_irq      <= |(r_capture & r_mask);
            r_readdata <= w_rdata;
        end
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk) begin
        if (!reset_n || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // Sample storage written with the synchronised word on each accepted push.
    // NOTE: the storage array is not reset; pointers and level define which entries are valid, which also lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_s;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
